// File: rtl/alu_seq_unit.sv
// Decoded ALU with a start/done handshake and registered result and flags.
// Define ALU_SEQ_MUL_EN to build in the WIDTH-cycle shift-add multiplier (func 5 under ALUop 01).
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       ALUop,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);

    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_RSB, OP_AND, OP_NOT, OP_MUL, OP_ILL} op_e;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

    state_e           state, state_nx;
    op_e              op;
    logic             accept;
    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin;
    logic [WIDTH+1:0] arith;
    logic [WIDTH-1:0] ex_res;
    logic             ex_c, ex_v, ex_ill;

    // Returns {signed overflow, carry-out, sum}; subtraction is x + ~y + 1.
    function automatic logic [WIDTH+1:0] add_cv(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             cin);
        logic [WIDTH:0] sum;
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        return {(x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]), sum};
    endfunction

    always_comb begin
        op = OP_ILL;
        case (ALUop)
            2'b00: op = OP_ADD;
            2'b10: op = OP_SUB;
            2'b11: op = OP_AND;
            default: begin
                case (func)
                    3'd0: op = OP_ADD;
                    3'd1: op = OP_SUB;
                    3'd2: op = OP_RSB;
                    3'd3: op = OP_AND;
                    3'd4: op = OP_NOT;
`ifdef ALU_SEQ_MUL_EN
                    3'd5: op = OP_MUL;
`endif
                    default: op = OP_ILL;
                endcase
            end
        endcase
    end

    // Single-cycle execute: one shared adder serves ADD, SUB and RSB.
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
        if (op == OP_SUB) begin
            add_y   = ~b;
            add_cin = 1'b1;
        end else if (op == OP_RSB) begin
            add_x   = b;
            add_y   = ~a;
            add_cin = 1'b1;
        end
        arith  = add_cv(add_x, add_y, add_cin);
        ex_res = '0;
        ex_c   = 1'b0;
        ex_v   = 1'b0;
        ex_ill = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_RSB: {ex_v, ex_c, ex_res} = arith;
            OP_AND:                 ex_res = a & b;
            OP_NOT:                 ex_res = ~a;
            OP_ILL:                 ex_ill = 1'b1;
            default:                ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                 mul_go, mul_last;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   mcand, acc, acc_nx;
    logic [WIDTH-1:0]     mplier;

    assign acc_nx = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (mul_go)
            cnt <= '0;
        else if (state == S_MUL)
            cnt <= cnt + CNT_W'(1);
    end

    // Multiplier datapath: no reset needed, always loaded on accept.
    always_ff @(posedge clk) begin
        if (mul_go) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign ready = (state != S_MUL);
`else
    assign ready = 1'b1;
`endif

    assign done = (state == S_DONE);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mul_go   = 1'b0;
        mul_last = 1'b0;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                state_nx = S_IDLE;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_DONE;
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        mul_go   = 1'b1;
                        state_nx = S_MUL;
                    end
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    mul_last = 1'b1;
                    state_nx = S_DONE;
                end
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            result  <= '0;
            zero    <= 1'b1;
            neg     <= 1'b0;
            carry   <= 1'b0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept)
                illegal <= ex_ill;
            if (accept && state_nx == S_DONE) begin
                result <= ex_res;
                zero   <= (ex_res == '0);
                neg    <= ex_res[WIDTH-1];
                carry  <= ex_c;
                ovf    <= ex_v;
            end
`ifdef ALU_SEQ_MUL_EN
            if (mul_last) begin
                result <= acc_nx[WIDTH-1:0];
                zero   <= (acc_nx[WIDTH-1:0] == '0);
                neg    <= acc_nx[WIDTH-1];
                carry  <= 1'b0;
                ovf    <= |acc_nx[2*WIDTH-1:WIDTH];
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit at WIDTH=8: directed table, handshake corner cases, randomized model check.
module tb_alu_seq_unit;
    localparam int W = 8;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [2:0] f;
        logic [7:0] a;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] aluop = '0;
    logic [2:0] func = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       ready, done, zero, neg, carry, ovf, illegal;
    logic [7:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUop(aluop), .func(func),
        .a(a), .b(b), .ready(ready), .done(done), .result(result),
        .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .illegal(illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {result, zero, neg, carry, ovf, illegal};
    endfunction

    function automatic exp_t mk_e(input logic [7:0] r, input logic z, input logic n,
                                  input logic c, input logic v, input logic i);
        exp_t e;
        e.res = r; e.z = z; e.n = n; e.c = c; e.v = v; e.ill = i;
        return e;
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f,
                                input logic [7:0] x, input logic [7:0] y, input exp_t e);
        vec_t t;
        t.op = op; t.f = f; t.a = x; t.b = y; t.e = e;
        return t;
    endfunction

    function automatic logic is_mul(input logic [1:0] op, input logic [2:0] f);
`ifdef ALU_SEQ_MUL_EN
        return (op == 2'b01) && (f == 3'd5);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f,
                                   input logic [7:0] x, input logic [7:0] y);
        int   ux, uy, sx, sy, r, s, k;
        exp_t e;
        ux = int'(x); uy = int'(y);
        sx = int'($signed(x)); sy = int'($signed(y));
        e = '0;
        r = 0;
        case (op)
            2'b00: k = 0;
            2'b10: k = 1;
            2'b11: k = 3;
            default: k = int'(f);
        endcase
        if (k == 5 && !is_mul(op, f)) k = 6;
        case (k)
            0: begin r = ux + uy; e.c = (r > 255); s = sx + sy; e.v = (s > 127) || (s < -128); end
            1: begin r = ux - uy; e.c = (ux >= uy); s = sx - sy; e.v = (s > 127) || (s < -128); end
            2: begin r = uy - ux; e.c = (uy >= ux); s = sy - sx; e.v = (s > 127) || (s < -128); end
            3: r = ux & uy;
            4: r = (~ux) & 255;
            5: begin r = ux * uy; e.v = (r > 255); end
            default: e.ill = 1'b1;
        endcase
        e.res = r[7:0];
        e.z   = (e.res == 8'h00);
        e.n   = e.res[7];
        return e;
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_outs"}, outs(), {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[12];
        exp_t       e;
        logic [1:0] op_r;
        logic [2:0] f_r;
        logic [7:0] a_r, b_r;
        logic       mulop, saw_done;
        int         n;

        tbl[0]  = mk(2'b00, 3'd0, 8'hF0, 8'h20, mk_e(8'h10, 0, 0, 1, 0, 0));
        tbl[1]  = mk(2'b01, 3'd2, 8'h05, 8'h03, mk_e(8'hFE, 0, 1, 0, 0, 0));
        tbl[2]  = mk(2'b01, 3'd6, 8'h12, 8'h34, mk_e(8'h00, 1, 0, 0, 0, 1));
        tbl[3]  = mk(2'b10, 3'd0, 8'h80, 8'h01, mk_e(8'h7F, 0, 0, 1, 1, 0));
        tbl[4]  = mk(2'b11, 3'd0, 8'h0F, 8'h3C, mk_e(8'h0C, 0, 0, 0, 0, 0));
        tbl[5]  = mk(2'b01, 3'd4, 8'h0F, 8'hAA, mk_e(8'hF0, 0, 1, 0, 0, 0));
        tbl[6]  = mk(2'b01, 3'd1, 8'h03, 8'h05, mk_e(8'hFE, 0, 1, 0, 0, 0));
        tbl[7]  = mk(2'b01, 3'd0, 8'h7F, 8'h01, mk_e(8'h80, 0, 1, 0, 1, 0));
        tbl[8]  = mk(2'b00, 3'd7, 8'hFF, 8'h01, mk_e(8'h00, 1, 0, 1, 0, 0));
        tbl[9]  = mk(2'b01, 3'd7, 8'h55, 8'h66, mk_e(8'h00, 1, 0, 0, 0, 1));
        tbl[10] = mk(2'b10, 3'd3, 8'h05, 8'h05, mk_e(8'h00, 1, 0, 1, 0, 0));
        tbl[11] = mk(2'b01, 3'd3, 8'hF0, 8'h3C, mk_e(8'h30, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table: one accept per edge, done held high throughout.
        foreach (tbl[i]) begin
            @(negedge clk);
            start = 1'b1; aluop = tbl[i].op; func = tbl[i].f; a = tbl[i].a; b = tbl[i].b;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done", i), done, 1);
            chk($sformatf("vec%0d_ready", i), ready, 1);
            chk($sformatf("vec%0d_outs", i), outs(), tbl[i].e);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_end_done", done, 0);
        chk("b2b_hold_result", result, 8'h30);

        // Asynchronous reset asserted mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_async");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ALU_SEQ_MUL_EN
        @(negedge clk);
        start = 1'b1; aluop = 2'b01; func = 3'd5; a = 8'h10; b = 8'h11;
        @(posedge clk);
        #1;
        for (int i = 0; i < W; i++) begin
            chk($sformatf("mul_busy%0d_ready", i), ready, 0);
            chk($sformatf("mul_busy%0d_done", i), done, 0);
            @(negedge clk);
            start = (i == 2); aluop = 2'b00; func = 3'd0; a = 8'h01; b = 8'h01;
            @(posedge clk);
            #1;
        end
        chk("mul_done", done, 1);
        chk("mul_ready", ready, 1);
        chk("mul_outs", outs(), {8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("mul_no_queue_done", done, 0);
        chk("mul_hold_result", result, 8'h10);

        // Reset during iteration 4 aborts the multiply without a done.
        @(negedge clk);
        start = 1'b1; aluop = 2'b01; func = 3'd5; a = 8'h10; b = 8'h11;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mulrst_busy", ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mulrst");
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        chk("mulrst_no_done", saw_done, 0);
        check_reset("mulrst_after");
`else
        @(negedge clk);
        start = 1'b1; aluop = 2'b01; func = 3'd5; a = 8'h10; b = 8'h11;
        @(posedge clk);
        #1;
        chk("func5_done", done, 1);
        chk("func5_ready", ready, 1);
        chk("func5_outs", outs(), {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        start = 1'b0;
`endif

        // Randomized ops; operands are scrambled while an op is in flight.
        for (int k = 0; k < 150; k++) begin
            op_r = 2'($urandom_range(0, 3));
            f_r  = 3'($urandom_range(0, 7));
            a_r  = pick();
            b_r  = pick();
            e     = model(op_r, f_r, a_r, b_r);
            mulop = is_mul(op_r, f_r);
            @(negedge clk);
            start = 1'b1; aluop = op_r; func = f_r; a = a_r; b = b_r;
            @(posedge clk);
            #1;
            start = 1'b0; a = 8'($urandom); b = 8'($urandom);
            n = 0;
            while (!done && n < 3 * W) begin
                @(posedge clk);
                #1;
                a = 8'($urandom); b = 8'($urandom);
                n++;
            end
            chk($sformatf("rnd%0d_done", k), done, 1);
            chk($sformatf("rnd%0d_latency", k), n, mulop ? W : 0);
            chk($sformatf("rnd%0d_outs op=%0d f=%0d a=%0h b=%0h", k, op_r, f_r, a_r, b_r), outs(), e);
            chk($sformatf("rnd%0d_ready", k), ready, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
